// File: rtl/cop0_exc_sequencer.sv
// cop0_exc_sequencer
// Exception-entry sequencer and owner of the single COP0 write port.
// When idle, pipeline MTC0/ERET writes pass straight through. A committed
// exception stalls the pipeline, then writes EPC (skipped if EXL was already
// set), Cause and Status in turn. With COP0_BADVADDR_EN defined, BadVAddr is
// also written when the faulting address is valid. The sequence ends with a
// one-cycle flush and a redirect to EXC_VECTOR.
// Optional feature macro: COP0_BADVADDR_EN
module cop0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [7:0]  pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_badvaddr_vld,
  input  logic [31:0] status_rdata,
  input  logic [31:0] cause_rdata,
  output logic        cop0_we,
  output logic [7:0]  cop0_addr,
  output logic [31:0] cop0_wdata,
  output logic        stall,
  output logic        flush,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
`ifdef COP0_BADVADDR_EN
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
`endif

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
`ifdef COP0_BADVADDR_EN
    W_BADVA,
`endif
    REDIRECT
  } state_t;

  state_t      state;
  logic [4:0]  l_code;
  logic [31:0] l_pc;
  logic        l_bd;
  logic        l_exl;
`ifdef COP0_BADVADDR_EN
  logic [31:0] l_bva;
  logic        l_bva_vld;
`else
  logic        unused_bva;
  assign unused_bva = ^{exc_badvaddr, exc_badvaddr_vld};
`endif

  // Sequencer state and the exception fields captured on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      l_code    <= '0;
      l_pc      <= '0;
      l_bd      <= 1'b0;
      l_exl     <= 1'b0;
`ifdef COP0_BADVADDR_EN
      l_bva     <= '0;
      l_bva_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (exc_req) begin
            l_code    <= exc_code;
            l_pc      <= exc_pc;
            l_bd      <= exc_bd;
            l_exl     <= status_rdata[1];
`ifdef COP0_BADVADDR_EN
            l_bva     <= exc_badvaddr;
            l_bva_vld <= exc_badvaddr_vld;
`endif
            state     <= status_rdata[1] ? W_CAUSE : W_EPC;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_STATUS;
`ifdef COP0_BADVADDR_EN
        W_STATUS: state <= l_bva_vld ? W_BADVA : REDIRECT;
        W_BADVA:  state <= REDIRECT;
`else
        W_STATUS: state <= REDIRECT;
`endif
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Write-port mux and control strobes; Cause/Status are read-modify-write
  // of the live register values, so these outputs are decoded from state
  // rather than registered. Everything is held at zero while reset is high.
  always_comb begin
    cop0_we      = 1'b0;
    cop0_addr    = '0;
    cop0_wdata   = '0;
    stall        = 1'b0;
    flush        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    busy         = 1'b0;
    if (!reset) begin
      busy  = (state != IDLE);
      stall = (state != IDLE);
      case (state)
        IDLE: begin
          if (exc_req) begin
            stall = 1'b1;
          end else begin
            cop0_we    = pipe_we;
            cop0_addr  = pipe_addr;
            cop0_wdata = pipe_wdata;
          end
        end
        W_EPC: begin
          cop0_we    = 1'b1;
          cop0_addr  = ADDR_EPC;
          cop0_wdata = l_bd ? (l_pc - 32'd4) : l_pc;
        end
        W_CAUSE: begin
          cop0_we    = 1'b1;
          cop0_addr  = ADDR_CAUSE;
          cop0_wdata = {(l_exl ? cause_rdata[31] : l_bd), cause_rdata[30:7],
                        l_code, cause_rdata[1:0]};
        end
        W_STATUS: begin
          cop0_we    = 1'b1;
          cop0_addr  = ADDR_STATUS;
          cop0_wdata = status_rdata | 32'h0000_0002;
        end
`ifdef COP0_BADVADDR_EN
        W_BADVA: begin
          cop0_we    = 1'b1;
          cop0_addr  = ADDR_BADVADDR;
          cop0_wdata = l_bva;
        end
`endif
        REDIRECT: begin
          flush        = 1'b1;
          redirect_vld = 1'b1;
          redirect_pc  = EXC_VECTOR;
        end
        default: begin
          cop0_we = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cop0_exc_sequencer.sv
// tb_cop0_exc_sequencer
// Randomized stimulus checked every cycle against a schedule-based model:
// an accepted exception expands into a queue of pending write/redirect
// actions, one consumed per cycle. Directed cases pin the model with
// hand-computed literal values. Honours COP0_BADVADDR_EN like the design.
module tb_cop0_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        exc_badvaddr_vld;
  logic [31:0] status_rdata;
  logic [31:0] cause_rdata;
  logic        cop0_we;
  logic [7:0]  cop0_addr;
  logic [31:0] cop0_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  cop0_exc_sequencer #(.EXC_VECTOR(32'hBFC0_0380)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .exc_badvaddr_vld(exc_badvaddr_vld),
    .status_rdata(status_rdata), .cause_rdata(cause_rdata),
    .cop0_we(cop0_we), .cop0_addr(cop0_addr), .cop0_wdata(cop0_wdata),
    .stall(stall), .flush(flush), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int K_EPC = 0, K_CAUSE = 1, K_STATUS = 2, K_BADVA = 3, K_REDIR = 4;
  typedef struct {
    int          kind;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        exl;
    logic [31:0] bva;
  } act_t;
  act_t sched[$];

  // Consume one pending action per cycle; an accepted exception schedules its actions
  always @(posedge clk) begin
    act_t a;
    if (reset) begin
      sched.delete();
    end else if (sched.size() != 0) begin
      void'(sched.pop_front());
    end else if (exc_req) begin
      a.code = exc_code; a.pc = exc_pc; a.bd = exc_bd;
      a.exl = status_rdata[1]; a.bva = exc_badvaddr;
      if (!a.exl) begin a.kind = K_EPC; sched.push_back(a); end
      a.kind = K_CAUSE;  sched.push_back(a);
      a.kind = K_STATUS; sched.push_back(a);
`ifdef COP0_BADVADDR_EN
      if (exc_badvaddr_vld) begin a.kind = K_BADVA; sched.push_back(a); end
`endif
      a.kind = K_REDIR;  sched.push_back(a);
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic        e_we, e_stall, e_busy, e_fl, e_rv;
    logic [7:0]  e_addr;
    logic [31:0] e_data;
    e_we = 0; e_stall = 0; e_busy = 0; e_fl = 0; e_rv = 0;
    e_addr = '0; e_data = '0;
    if (reset) begin
      e_we = 0;
    end else if (sched.size() == 0) begin
      if (exc_req) e_stall = 1;
      else begin e_we = pipe_we; e_addr = pipe_addr; e_data = pipe_wdata; end
    end else begin
      e_busy = 1; e_stall = 1;
      case (sched[0].kind)
        K_EPC:    begin e_we = 1; e_addr = 8'h70; e_data = sched[0].pc - (sched[0].bd ? 32'd4 : 32'd0); end
        K_CAUSE:  begin
          e_we = 1; e_addr = 8'h68; e_data = cause_rdata;
          e_data[6:2] = sched[0].code;
          if (!sched[0].exl) e_data[31] = sched[0].bd;
        end
        K_STATUS: begin e_we = 1; e_addr = 8'h60; e_data = status_rdata | 32'h2; end
        K_BADVA:  begin e_we = 1; e_addr = 8'h40; e_data = sched[0].bva; end
        default:  begin e_fl = 1; e_rv = 1; end
      endcase
    end
    chk("m_we", cop0_we, e_we);
    if (e_we) begin
      chk("m_addr", cop0_addr, e_addr);
      chk("m_wdata", cop0_wdata, e_data);
    end
    chk("m_stall", stall, e_stall);
    chk("m_busy", busy, e_busy);
    chk("m_flush", flush, e_fl);
    chk("m_redir_vld", redirect_vld, e_rv);
    if (e_rv) chk("m_redir_pc", redirect_pc, 32'hBFC0_0380);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    reset = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
    exc_req = 0; exc_code = '0; exc_pc = '0; exc_bd = 0;
    exc_badvaddr = '0; exc_badvaddr_vld = 0; status_rdata = '0; cause_rdata = '0;
  endtask

  task automatic start_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] st, input logic [31:0] ca);
    exc_req = 1; exc_code = code; exc_pc = pc; exc_bd = bd;
    status_rdata = st; cause_rdata = ca;
  endtask

  initial begin
    int redirs, bad;
    set_idle();
    reset = 1; pipe_we = 1; pipe_addr = 8'h60; pipe_wdata = 32'h1234_5678; exc_req = 1;
    @(negedge clk);
    chk("rst_we", cop0_we, 0); chk("rst_stall", stall, 0); chk("rst_busy", busy, 0);
    chk("rst_flush", flush, 0); chk("rst_wdata", cop0_wdata, 0);
    tick(); tick();
    set_idle(); tick();

    // Pass-through
    pipe_we = 1; pipe_addr = 8'h60; pipe_wdata = 32'h0000_FF01;
    @(negedge clk);
    chk("pt_we", cop0_we, 1); chk("pt_addr", cop0_addr, 8'h60);
    chk("pt_data", cop0_wdata, 32'h0000_FF01); chk("pt_stall", stall, 0);
    tick(); set_idle(); tick();

    // Basic entry
    start_exc(5'h0C, 32'h8000_1000, 0, 32'h0, 32'h0);
    @(negedge clk); chk("be0_we", cop0_we, 0); chk("be0_stall", stall, 1);
    tick(); exc_req = 0;
    @(negedge clk); chk("be1_addr", cop0_addr, 8'h70); chk("be1_data", cop0_wdata, 32'h8000_1000);
    tick();
    @(negedge clk); chk("be2_addr", cop0_addr, 8'h68); chk("be2_data", cop0_wdata, 32'h0000_0030);
    tick();
    @(negedge clk); chk("be3_addr", cop0_addr, 8'h60); chk("be3_data", cop0_wdata, 32'h0000_0002);
    tick();
    @(negedge clk); chk("be4_rv", redirect_vld, 1); chk("be4_pc", redirect_pc, 32'hBFC0_0380);
    chk("be4_stall", stall, 1); chk("be4_we", cop0_we, 0);
    tick();
    @(negedge clk); chk("be5_busy", busy, 0); chk("be5_flush", flush, 0);
    tick();

    // Delay slot
    start_exc(5'h0C, 32'h8000_1004, 1, 32'h0, 32'h0);
    tick(); exc_req = 0;
    @(negedge clk); chk("ds_epc", cop0_wdata, 32'h8000_1000);
    tick();
    @(negedge clk); chk("ds_cause", cop0_wdata, 32'h8000_0030);
    tick(); tick(); tick(); tick();

    // EXL already set
    start_exc(5'h04, 32'h8000_2000, 1, 32'h2, 32'h0);
    tick(); exc_req = 0;
    @(negedge clk); chk("exl1_addr", cop0_addr, 8'h68); chk("exl1_data", cop0_wdata, 32'h0000_0010);
    tick();
    @(negedge clk); chk("exl2_addr", cop0_addr, 8'h60); chk("exl2_data", cop0_wdata, 32'h0000_0002);
    tick();
    @(negedge clk); chk("exl3_rv", redirect_vld, 1);
    tick();
    @(negedge clk); chk("exl4_busy", busy, 0);
    tick();

    // Collision with pipeline write, second exc_req while busy
    start_exc(5'h0C, 32'h8000_3000, 0, 32'h0, 32'h0);
    pipe_we = 1; pipe_addr = 8'h08; pipe_wdata = 32'hDEAD_BEEF;
    redirs = 0; bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) exc_req = 0;
      if (c == 2) exc_req = 1;
      if (c == 3) exc_req = 0;
      if (c == 5) pipe_we = 0;
      @(negedge clk);
      if (redirect_vld) redirs++;
      if (c < 5 && cop0_we && cop0_addr == 8'h08) bad++;
      if (c == 4) chk("coll_redir_we", cop0_we, 0);
      tick();
    end
    chk("coll_redirs", redirs, 1); chk("coll_pipe_writes", bad, 0);
    set_idle(); tick();

    // Reset mid-sequence
    start_exc(5'h0C, 32'h8000_4000, 0, 32'h0, 32'h0);
    redirs = 0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) exc_req = 0;
      if (c == 2) reset = 1;
      if (c == 3) reset = 0;
      if (c == 4) begin pipe_we = 1; pipe_addr = 8'h60; pipe_wdata = 32'h0000_FF01; end
      if (c == 5) pipe_we = 0;
      @(negedge clk);
      if (redirect_vld) redirs++;
      if (c < 4 && cop0_we && cop0_addr == 8'h60) bad++;
      if (c == 2) begin chk("rm2_we", cop0_we, 0); chk("rm2_stall", stall, 0); end
      if (c == 3) chk("rm3_busy", busy, 0);
      if (c == 4) begin chk("rm4_we", cop0_we, 1); chk("rm4_data", cop0_wdata, 32'h0000_FF01); end
      tick();
    end
    chk("rm_redirs", redirs, 0); chk("rm_status_writes", bad, 0);
    set_idle(); tick();

    // BadVAddr valid
    start_exc(5'h04, 32'h8000_5000, 0, 32'h0, 32'h0);
    exc_badvaddr = 32'h0000_0013; exc_badvaddr_vld = 1;
    tick(); set_idle(); tick(); tick(); tick();
    @(negedge clk);
`ifdef COP0_BADVADDR_EN
    chk("bva4_addr", cop0_addr, 8'h40); chk("bva4_data", cop0_wdata, 32'h0000_0013);
    tick();
    @(negedge clk); chk("bva5_rv", redirect_vld, 1);
`else
    chk("bva4_rv", redirect_vld, 1); chk("bva4_we", cop0_we, 0);
`endif
    tick(); tick();

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(63) == 0);
      exc_req          = ($urandom_range(5) == 0);
      pipe_we          = $urandom_range(1);
      pipe_addr        = 8'($urandom);
      pipe_wdata       = $urandom;
      exc_code         = 5'($urandom);
      exc_pc           = $urandom;
      exc_bd           = $urandom_range(1);
      exc_badvaddr     = $urandom;
      exc_badvaddr_vld = $urandom_range(1);
      status_rdata     = $urandom;
      cause_rdata      = $urandom;
      tick();
    end
    set_idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
